// File: rtl/auth_session_controller.sv
// auth_session_controller
//   Session controller around the combinational permission circuit. A login
//   code is latched and driven out on code_out. The resulting permission
//   vector is sampled one cycle later. On success a session opens that gates
//   req against the sampled permissions. The session closes on logout or
//   after TIMEOUT idle cycles.
//
//   Optional feature: define AUTH_LOCKOUT_EN to build the LOCKED state.
//   MAX_FAILS consecutive failed logins then lock the user out for
//   LOCK_CYCLES cycles. Without it, failures always return to IDLE and lock
//   is tied 0.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   login, logout   level controls, sampled every cycle
//   user_code[2:0]  {A,B,C} login code, sampled with login
//   code_out[2:0]   latched code driven to the permission circuit
//   perm_in[0:6]    permission vector P[0:6] returned for code_out
//   req[0:6]        per-resource access requests
//   grant[0:6]      registered grants (req & sampled permissions)
//   session_active  high while a session is open
//   timeout         one-cycle pulse after an inactivity logout
//   lock            high while locked out
//   fail_count      consecutive failed logins (saturating)
module auth_session_controller #(
  parameter int TIMEOUT     = 8,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           login,
  input  logic                           logout,
  input  logic [2:0]                     user_code,
  output logic [2:0]                     code_out,
  input  logic [0:6]                     perm_in,
  input  logic [0:6]                     req,
  output logic [0:6]                     grant,
  output logic                           session_active,
  output logic                           timeout,
  output logic                           lock,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

  localparam int FCW = $clog2(MAX_FAILS + 1);
  localparam int TW  = $clog2(TIMEOUT);

  if (TIMEOUT < 2)     begin : g_chk_to  $error("TIMEOUT must be >= 2");     end
  if (MAX_FAILS < 1)   begin : g_chk_mf  $error("MAX_FAILS must be >= 1");   end
  if (LOCK_CYCLES < 1) begin : g_chk_lc  $error("LOCK_CYCLES must be >= 1"); end

  typedef enum logic [1:0] {IDLE, EVAL, ACTIVE, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [2:0]     code_q, code_d;
  logic [0:6]     perm_q, perm_d;
  logic [0:6]     grant_q, grant_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [FCW-1:0] fail_q, fail_d;
  logic           timeout_q, timeout_d;

`ifdef AUTH_LOCKOUT_EN
  localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  logic [LCW-1:0] lcnt_q, lcnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    perm_d    = perm_q;
    grant_d   = '0;
    timer_d   = timer_q;
    fail_d    = fail_q;
    timeout_d = 1'b0;
`ifdef AUTH_LOCKOUT_EN
    lcnt_d    = lcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (login) begin
          code_d  = user_code;
          state_d = EVAL;
        end
      end
      EVAL: begin
        // P[0] alone does not grant a session; only P[1:6] decide success.
        if (perm_in[1:6] == 6'b0) begin
          fail_d  = (fail_q == FCW'(MAX_FAILS)) ? fail_q : fail_q + FCW'(1);
          code_d  = '0;
          state_d = IDLE;
`ifdef AUTH_LOCKOUT_EN
          if (fail_d == FCW'(MAX_FAILS)) begin
            state_d = LOCKED;
            lcnt_d  = LCW'(LOCK_CYCLES - 1);
          end
`endif
        end else begin
          perm_d  = perm_in;
          fail_d  = '0;
          timer_d = TW'(TIMEOUT - 1);
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (logout) begin
          perm_d  = '0;
          code_d  = '0;
          state_d = IDLE;
        end else if (|req) begin
          grant_d = req & perm_q;
          timer_d = TW'(TIMEOUT - 1);
        end else if (timer_q == '0) begin
          // Pulse lands in the first IDLE cycle.
          timeout_d = 1'b1;
          perm_d    = '0;
          code_d    = '0;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
`ifdef AUTH_LOCKOUT_EN
      LOCKED: begin
        if (lcnt_q == '0) begin
          fail_d  = '0;
          state_d = IDLE;
        end else begin
          lcnt_d = lcnt_q - LCW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      code_q    <= '0;
      perm_q    <= '0;
      grant_q   <= '0;
      timer_q   <= '0;
      fail_q    <= '0;
      timeout_q <= 1'b0;
`ifdef AUTH_LOCKOUT_EN
      lcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      perm_q    <= perm_d;
      grant_q   <= grant_d;
      timer_q   <= timer_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
`ifdef AUTH_LOCKOUT_EN
      lcnt_q    <= lcnt_d;
`endif
    end
  end

  assign code_out       = code_q;
  assign grant          = grant_q;
  assign session_active = (state_q == ACTIVE);
  assign timeout        = timeout_q;
  assign fail_count     = fail_q;
`ifdef AUTH_LOCKOUT_EN
  assign lock = (state_q == LOCKED);
`else
  assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_auth_session_controller.sv
module tb_auth_session_controller;

  localparam int TIMEOUT     = 8;
  localparam int MAX_FAILS   = 3;
  localparam int LOCK_CYCLES = 16;
  localparam int FCW         = $clog2(MAX_FAILS + 1);
`ifdef AUTH_LOCKOUT_EN
  localparam bit LOCKOUT = 1'b1;
`else
  localparam bit LOCKOUT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           login = 1'b0, logout = 1'b0;
  logic [2:0]     user_code = '0;
  logic [2:0]     code_out;
  logic [0:6]     perm_in, req = '0, grant;
  logic           session_active, timeout, lock;
  logic [FCW-1:0] fail_count;

  always #5 clk = ~clk;

  // Stand-in for the combinational permission circuit. 000 and 110 fail
  // (P[1:6] zero); 000 deliberately carries P[0]=1.
  function automatic logic [0:6] perm_tbl(input logic [2:0] c);
    case (c)
      3'b000:  return 7'b1000000;
      3'b001:  return 7'b0100001;
      3'b010:  return 7'b1010100;
      3'b011:  return 7'b1111010;
      3'b100:  return 7'b0001111;
      3'b101:  return 7'b1111111;
      3'b110:  return 7'b0000000;
      default: return 7'b1100110;
    endcase
  endfunction

  assign perm_in = perm_tbl(code_out);

  auth_session_controller #(
    .TIMEOUT(TIMEOUT), .MAX_FAILS(MAX_FAILS), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .login(login), .logout(logout),
    .user_code(user_code), .code_out(code_out), .perm_in(perm_in),
    .req(req), .grant(grant), .session_active(session_active),
    .timeout(timeout), .lock(lock), .fail_count(fail_count)
  );

  typedef struct packed {
    logic [2:0]     code;
    logic [0:6]     grant;
    logic           sa;
    logic           tmo;
    logic           lk;
    logic [FCW-1:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: session described by flags, a count of quiet cycles
  // and a count of lockout cycles still to serve.
  bit         m_pending, m_sess, m_locked, m_tmo;
  int         m_quiet, m_lock_left, m_fails;
  logic [2:0] m_code;
  logic [0:6] m_perm, m_grant;

  task automatic model_step();
    logic [0:6] p;
    if (rst) begin
      m_pending = 0; m_sess = 0; m_locked = 0; m_tmo = 0;
      m_quiet = 0; m_lock_left = 0; m_fails = 0;
      m_code = '0; m_perm = '0; m_grant = '0;
      return;
    end
    m_tmo   = 0;
    m_grant = '0;
    if (m_locked) begin
      m_lock_left--;
      if (m_lock_left == 0) begin m_locked = 0; m_fails = 0; end
    end else if (m_pending) begin
      m_pending = 0;
      p = perm_tbl(m_code);
      if (p[1:6] == 6'b0) begin
        if (m_fails < MAX_FAILS) m_fails++;
        m_code = '0;
        if (LOCKOUT && m_fails == MAX_FAILS) begin
          m_locked = 1; m_lock_left = LOCK_CYCLES;
        end
      end else begin
        m_perm = p; m_fails = 0; m_sess = 1; m_quiet = 0;
      end
    end else if (m_sess) begin
      if (logout) begin
        m_sess = 0; m_perm = '0; m_code = '0;
      end else if (req != '0) begin
        m_grant = req & m_perm;
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet == TIMEOUT) begin
          m_sess = 0; m_tmo = 1; m_perm = '0; m_code = '0;
        end
      end
    end else if (login) begin
      m_code = user_code; m_pending = 1;
    end
  endtask

  task automatic cyc(input logic r, input logic li, input logic lo,
                     input logic [2:0] uc, input logic [0:6] rq);
    exp_t e;
    @(negedge clk);
    rst = r; login = li; logout = lo; user_code = uc; req = rq;
    model_step();
    e.code = m_code; e.grant = m_grant; e.sa = m_sess; e.tmo = m_tmo;
    e.lk = m_locked; e.fc = FCW'(m_fails);
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every edge the DUT presents a new output set; pop and compare.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("code_out",       32'(code_out),       32'(e.code));
      check("grant",          32'(grant),          32'(e.grant));
      check("session_active", 32'(session_active), 32'(e.sa));
      check("timeout",        32'(timeout),        32'(e.tmo));
      check("lock",           32'(lock),           32'(e.lk));
      check("fail_count",     32'(fail_count),     32'(e.fc));
    end
  end

  initial begin
    logic [0:6] ones, rq;
    ones = '1;
    repeat (3) cyc(1, 0, 0, 3'b000, '0);

    // Login 011, exercise grants, then reset mid-session with req all ones.
    cyc(0, 1, 0, 3'b011, '0);
    cyc(0, 0, 0, 3'b000, '0);
    cyc(0, 0, 0, 3'b000, ones);
    cyc(0, 1, 0, 3'b111, ones);
    cyc(1, 0, 0, 3'b000, ones);
    cyc(0, 0, 0, 3'b000, '0);

    // Login 101, then inactivity with a request restarting the count.
    cyc(0, 1, 0, 3'b101, '0);
    cyc(0, 0, 0, 3'b000, '0);
    cyc(0, 0, 0, 3'b000, ones);
    repeat (4) cyc(0, 0, 0, 3'b000, '0);
    cyc(0, 0, 0, 3'b000, 7'b0010000);
    repeat (11) cyc(0, 0, 0, 3'b000, '0);

    // logout wins over a simultaneous request.
    cyc(0, 1, 0, 3'b101, '0);
    cyc(0, 0, 0, 3'b000, '0);
    cyc(0, 0, 0, 3'b000, ones);
    cyc(0, 0, 1, 3'b000, ones);
    cyc(0, 0, 0, 3'b000, '0);

    // Repeated failures: lockout (or saturation), login held during lock.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, (i == 3) ? 3'b110 : 3'b000, '0);
      cyc(0, 0, 0, 3'b000, '0);
    end
    repeat (LOCK_CYCLES + 2) cyc(0, 1, 0, 3'b000, '0);
    repeat (3) cyc(0, 0, 0, 3'b000, '0);

    // Two failures, then a success clears the count.
    cyc(1, 0, 0, 3'b000, '0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 0, 3'b110, '0);
      cyc(0, 0, 0, 3'b000, '0);
    end
    cyc(0, 1, 0, 3'b101, '0);
    cyc(0, 0, 0, 3'b000, '0);
    cyc(0, 0, 1, 3'b000, '0);
    cyc(0, 0, 0, 3'b000, '0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rq = ($urandom_range(9) < 3) ? 7'($urandom) : 7'b0;
      cyc(($urandom_range(199) == 0), 1'($urandom_range(1)),
          ($urandom_range(15) == 0), 3'($urandom_range(7)), rq);
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
